// File: rtl/mem_stage.sv
// EX/MEM pipeline register plus data memory: byte/half/word loads and stores with sticky misalignment flag.
// Outputs follow the registered EX/MEM state and are valid in the cycle after capture; stall freezes the stage.
module mem_stage #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        regwrite,
  input  logic        memtoreg,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        lunsigned,
  input  logic [31:0] aluresult,
  input  logic [31:0] writedata,
  input  logic [4:0]  writereg,
  output logic        regwriteo,
  output logic        memtorego,
  output logic [4:0]  writerego,
  output logic [31:0] aluresulto,
  output logic [31:0] readdata,
  output logic        exc,
  output logic [31:0] badaddr
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  regwrite_q, memtoreg_q, memread_q, memwrite_q, lunsigned_q;
  logic [1:0]            size_q;
  logic [31:0]           aluresult_q, writedata_q;
  logic [4:0]            writereg_q;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]            a;
  logic                  mis, we;
  logic [3:0]            be;
  logic [31:0]           wdat, rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      size_q      <= 2'b00;
      lunsigned_q <= 1'b0;
      aluresult_q <= 32'h0;
      writedata_q <= 32'h0;
      writereg_q  <= 5'h0;
    end else if (!stall) begin
      regwrite_q  <= regwrite;
      memtoreg_q  <= memtoreg;
      memread_q   <= memread;
      memwrite_q  <= memwrite;
      size_q      <= size;
      lunsigned_q <= lunsigned;
      aluresult_q <= aluresult;
      writedata_q <= writedata;
      writereg_q  <= writereg;
    end
  end

  // Upper address bits are dropped, so accesses wrap modulo the array size.
  assign widx = aluresult_q[DEPTH_LOG2+1:2];
  assign a    = aluresult_q[1:0];
  assign mis  = (memread_q | memwrite_q) &
                (((size_q == 2'b01) & a[0]) | (size_q[1] & (a != 2'b00)));
  assign we   = memwrite_q & ~mis & ~stall & ~rst;

  always_comb begin
    be   = 4'b1111;
    wdat = writedata_q;
    case (size_q)
      2'b00: begin
        be   = 4'b0001 << a;
        wdat = {4{writedata_q[7:0]}};
      end
      2'b01: begin
        be   = a[1] ? 4'b1100 : 4'b0011;
        wdat = {2{writedata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_comb begin
    rword = mem[widx];
    case (a)
      2'b00:   rbyte = rword[7:0];
      2'b01:   rbyte = rword[15:8];
      2'b10:   rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf    = a[1] ? rword[31:16] : rword[15:0];
    readdata = 32'h0;
    if (memread_q && !mis) begin
      case (size_q)
        2'b00:   readdata = lunsigned_q ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
        2'b01:   readdata = lunsigned_q ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
        default: readdata = rword;
      endcase
    end
  end

  // Only the first misaligned access is recorded; later ones leave badaddr alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc     <= 1'b0;
      badaddr <= 32'h0;
    end else if (mis && !stall && !exc) begin
      exc     <= 1'b1;
      badaddr <= aluresult_q;
    end
  end

  assign regwriteo  = regwrite_q & ~stall & ~mis;
  assign memtorego  = memtoreg_q;
  assign writerego  = writereg_q;
  assign aluresulto = aluresult_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-array reference model, randomized and directed stimulus.
module tb_mem_stage;
  localparam int DL2   = 8;
  localparam int DEPTH = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst, stall, flush, regwrite, memtoreg, memread, memwrite, lunsigned;
  logic [1:0]  size;
  logic [31:0] aluresult, writedata;
  logic [4:0]  writereg;
  logic        regwriteo, memtorego, exc;
  logic [4:0]  writerego;
  logic [31:0] aluresulto, readdata, badaddr;

  mem_stage #(.DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread), .memwrite(memwrite),
    .size(size), .lunsigned(lunsigned), .aluresult(aluresult), .writedata(writedata),
    .writereg(writereg), .regwriteo(regwriteo), .memtorego(memtorego),
    .writerego(writerego), .aluresulto(aluresulto), .readdata(readdata),
    .exc(exc), .badaddr(badaddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        regwrite, memtoreg, memread, memwrite;
    logic [1:0]  size;
    logic        lunsigned;
    logic [31:0] addr, wdata;
    logic [4:0]  wreg;
  } txn_t;

  typedef struct packed {
    logic        rw, mt;
    logic [4:0]  wr;
    logic [31:0] alu, rd;
    logic        ex;
    logic [31:0] bad;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  // Reference state: byte-addressed memory and the instruction sitting in MEM.
  logic [7:0]  bm [4*DEPTH];
  logic [31:0] pre [DEPTH];
  txn_t        m_cur;
  logic        m_exc;
  logic [31:0] m_bad;
  bit          mvalid = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input txn_t c);
    int n = nbytes(c.size);
    if (!(c.memread || c.memwrite)) return 0;
    return (c.addr % n) != 0;
  endfunction

  function automatic int base_of(input txn_t c);
    int ba = int'(c.addr & 32'(4*DEPTH-1));
    return ba - (ba % nbytes(c.size));
  endfunction

  function automatic logic [31:0] mload(input txn_t c);
    int n = nbytes(c.size);
    int b = base_of(c);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(bm[b+k]) << (8*k));
    if (n < 4 && !c.lunsigned && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  function automatic exp_t expect_now(input bit st);
    exp_t e;
    bit   m = is_mis(m_cur);
    e.rw  = m_cur.regwrite && !st && !m;
    e.mt  = m_cur.memtoreg;
    e.wr  = m_cur.wreg;
    e.alu = m_cur.addr;
    e.rd  = (m_cur.memread && !m) ? mload(m_cur) : 32'h0;
    e.ex  = m_exc;
    e.bad = m_bad;
    return e;
  endfunction

  task automatic commit(input txn_t t, input bit st, input bit fl, input bit rs);
    if (rs) begin
      m_cur  = '0;
      m_exc  = 0;
      m_bad  = 32'h0;
      mvalid = 1;
    end else begin
      if (m_cur.memwrite && !is_mis(m_cur) && !st) begin
        int b = base_of(m_cur);
        for (int k = 0; k < nbytes(m_cur.size); k++) bm[b+k] = m_cur.wdata[8*k +: 8];
      end
      if (is_mis(m_cur) && !st && !m_exc) begin
        m_exc = 1;
        m_bad = m_cur.addr;
      end
      if (fl) m_cur = '0;
      else if (!st) m_cur = t;
    end
  endtask

  task automatic drive(input txn_t t, input bit st, input bit fl, input bit rs);
    rst = rs; stall = st; flush = fl;
    regwrite = t.regwrite; memtoreg = t.memtoreg; memread = t.memread; memwrite = t.memwrite;
    size = t.size; lunsigned = t.lunsigned; aluresult = t.addr; writedata = t.wdata;
    writereg = t.wreg;
  endtask

  // One pipeline cycle: drive, queue the expected outputs, clock, update the model.
  task automatic step(input txn_t t, input bit st, input bit fl, input bit rs);
    drive(t, st, fl, rs);
    if (mvalid) exp_q.push_back(expect_now(st));
    @(posedge clk);
    commit(t, st, fl, rs);
    #1;
  endtask

  function automatic txn_t mk(input bit rw, input bit mt, input bit rd, input bit wr,
                              input logic [1:0] sz, input bit lu, input logic [31:0] a,
                              input logic [31:0] wd, input logic [4:0] r);
    txn_t t;
    t.regwrite = rw; t.memtoreg = mt; t.memread = rd; t.memwrite = wr;
    t.size = sz; t.lunsigned = lu; t.addr = a; t.wdata = wd; t.wreg = r;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int          op  = $urandom_range(0, 3);
    logic [1:0]  sz  = 2'($urandom_range(0, 3));
    logic [31:0] a   = 32'($urandom_range(0, 63) * 4 + DEPTH * 4 * $urandom_range(0, 2));
    logic [31:0] wd  = $urandom;
    logic [4:0]  r   = 5'($urandom_range(0, 31));
    bit          lu  = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
    else if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
    else if (sz == 2'b01) a = a + 32'(2 * $urandom_range(0, 1));
    case (op)
      0:       return mk(1'($urandom_range(0, 1)), 0, 0, 0, sz, lu, $urandom, wd, r);
      1:       return mk(1, 0, 0, 0, sz, lu, $urandom, wd, r);
      2:       return mk(1, 1, 1, 0, sz, lu, a, wd, r);
      default: return mk(0, 0, 0, 1, sz, lu, a, wd, r);
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      cmp("mon regwriteo",  {31'h0, regwriteo}, {31'h0, mon_e.rw});
      cmp("mon memtorego",  {31'h0, memtorego}, {31'h0, mon_e.mt});
      cmp("mon writerego",  {27'h0, writerego}, {27'h0, mon_e.wr});
      cmp("mon aluresulto", aluresulto, mon_e.alu);
      cmp("mon readdata",   readdata, mon_e.rd);
      cmp("mon exc",        {31'h0, exc}, {31'h0, mon_e.ex});
      cmp("mon badaddr",    badaddr, mon_e.bad);
    end
  end

  initial begin
    txn_t nop;
    nop = '0;
    m_cur = '0; m_exc = 0; m_bad = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      pre[i] = $urandom;
      dut.mem[i] = pre[i];
      for (int k = 0; k < 4; k++) bm[4*i+k] = pre[i][8*k +: 8];
    end
    drive(nop, 0, 0, 1);
    #1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(rand_txn(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    cmp("rst regwriteo", {31'h0, regwriteo}, 32'h0);
    cmp("rst writerego", {27'h0, writerego}, 32'h0);
    cmp("rst aluresulto", aluresulto, 32'h0);
    cmp("rst readdata", readdata, 32'h0);
    cmp("rst exc", {31'h0, exc}, 32'h0);
    cmp("rst badaddr", badaddr, 32'h0);

    // Word store then load
    step(mk(0, 0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0), 0, 0, 0);
    step(mk(1, 1, 1, 0, 2'b10, 0, 32'h10, 0, 5'd7), 0, 0, 0);
    cmp("lw readdata", readdata, 32'hDEADBEEF);
    cmp("lw regwriteo", {31'h0, regwriteo}, 32'h1);
    cmp("lw memtorego", {31'h0, memtorego}, 32'h1);
    cmp("lw writerego", {27'h0, writerego}, 32'd7);

    // Byte/half extension
    step(mk(0, 0, 0, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 0), 0, 0, 0);
    step(mk(1, 1, 1, 0, 2'b00, 0, 32'h23, 0, 5'd1), 0, 0, 0);
    cmp("lb 0x23", readdata, 32'hFFFFFF80);
    step(mk(1, 1, 1, 0, 2'b00, 1, 32'h23, 0, 5'd2), 0, 0, 0);
    cmp("lbu 0x23", readdata, 32'h00000080);
    step(mk(1, 1, 1, 0, 2'b01, 0, 32'h20, 0, 5'd3), 0, 0, 0);
    cmp("lh 0x20", readdata, 32'h00007F01);
    step(mk(1, 1, 1, 0, 2'b01, 0, 32'h22, 0, 5'd4), 0, 0, 0);
    cmp("lh 0x22", readdata, 32'hFFFF80FF);
    step(mk(0, 0, 0, 1, 2'b00, 0, 32'h21, 32'h123456AA, 0), 0, 0, 0);
    step(nop, 0, 0, 0);
    cmp("sb 0x21 word", dut.mem[8], 32'h80FFAA01);

    // Store held by stall lands exactly once after release
    step(mk(0, 0, 0, 1, 2'b10, 0, 32'h40, 32'h11223344, 0), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(nop, 1, 0, 0);
      cmp("stalled sw no write", dut.mem[16], pre[16]);
      cmp("stalled regwriteo", {31'h0, regwriteo}, 32'h0);
    end
    step(nop, 0, 0, 0);
    cmp("sw after stall", dut.mem[16], 32'h11223344);
    step(mk(1, 0, 0, 0, 2'b10, 0, 32'h1234, 0, 5'd9), 0, 0, 0);
    step(nop, 1, 0, 0);
    cmp("alu under stall regwriteo", {31'h0, regwriteo}, 32'h0);
    stall = 0;
    #1;
    cmp("alu released regwriteo", {31'h0, regwriteo}, 32'h1);
    step(nop, 0, 0, 0);

    // Flush while a store is in EX, then address wrap
    step(mk(0, 0, 0, 1, 2'b10, 0, 32'h50, 32'hCAFEF00D, 0), 0, 1, 0);
    cmp("flush regwriteo", {31'h0, regwriteo}, 32'h0);
    cmp("flush memtorego", {31'h0, memtorego}, 32'h0);
    cmp("flush aluresulto", aluresulto, 32'h0);
    step(nop, 0, 0, 0);
    cmp("flush no write", dut.mem[20], pre[20]);
    step(mk(0, 0, 0, 1, 2'b10, 0, 32'(4*DEPTH + 4), 32'h5A5AA5A5, 0), 0, 0, 0);
    step(nop, 0, 0, 0);
    cmp("wrap alias word 1", dut.mem[1], 32'h5A5AA5A5);

    // Misaligned accesses
    step(mk(1, 1, 1, 0, 2'b10, 0, 32'h06, 0, 5'd3), 0, 0, 0);
    cmp("mis lw readdata", readdata, 32'h0);
    cmp("mis lw regwriteo", {31'h0, regwriteo}, 32'h0);
    step(mk(0, 0, 0, 1, 2'b01, 0, 32'h09, 32'hBEEF, 0), 0, 0, 0);
    cmp("mis exc", {31'h0, exc}, 32'h1);
    cmp("mis badaddr", badaddr, 32'h06);
    step(nop, 0, 0, 0);
    cmp("mis sh no write", dut.mem[2], pre[2]);
    cmp("badaddr sticky", badaddr, 32'h06);

    // Randomized traffic with occasional stall, flush and reset
    step(nop, 0, 0, 1);
    for (int i = 0; i < 800; i++)
      step(rand_txn(), $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 99) == 0);
    step(nop, 0, 0, 0);
    @(negedge clk);
    cmp("scoreboard drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline: the EX/MEM pipeline register and the data memory. It sits between the execute stage and the MEM/WB register. It registers EX results, performs byte/half/word loads and stores with little-endian lane selection and sign/zero extension, and presents readdata, aluresult, writereg and control bits to MEM/WB. It also supports stall, flush and sticky misalignment detection.

## Interface
- DEPTH_LOG2, 8, log2 of data memory depth in 32-bit words (default 256 words)
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold EX/MEM register, suppress memory write and regwrite_o
- flush  in  1  load a bubble into EX/MEM (all control bits 0)
- regwrite  in  1  EX: instruction writes the register file
- memtoreg  in  1  EX: writeback source is memory
- memread  in  1  EX: load
- memwrite  in  1  EX: store
- size  in  2  EX: 00 byte, 01 half, 10 word, 11 treated as word
- lunsigned  in  1  EX: zero-extend loads (lbu/lhu)
- aluresult  in  32  EX: ALU result / effective address
- writedata  in  32  EX: store data (rt)
- writereg  in  5  EX: destination register
- regwriteo  out  1  to MEM/WB
- memtorego  out  1  to MEM/WB
- writerego  out  5  to MEM/WB
- aluresulto  out  32  to MEM/WB; also the forwarding value
- readdata  out  32  to MEM/WB: extended load data
- exc  out  1  sticky misaligned-access flag
- badaddr  out  32  address of the first misaligned access

## Operation
- EX/MEM register (regwrite_q, memtoreg_q, memread_q, memwrite_q, size_q, lunsigned_q, aluresult_q, writedata_q, writereg_q):
  - priority: rst > flush > stall > load
  - rst and flush clear every field to 0
  - stall holds all fields
- Word address: aluresult_q[DEPTH_LOG2+1:2]. Upper bits are ignored, so addresses wrap modulo the memory size.
- Alignment:
  - mis = (memread_q | memwrite_q) & ((size_q==01 & a[0]) | (size_q[1] & a[1:0]!=0)), where a = aluresult_q
  - byte accesses are never misaligned
- Load path is combinational from the array:
  - byte: lane a[1:0] (lane 0 = bits 7:0)
  - half: lane a[1] (bits 15:0 or 31:16)
  - sign-extended unless lunsigned_q; a word passes through unchanged
  - readdata = 0 when memread_q=0 or mis=1
- Store path:
  - byte enables: byte → 1<<a[1:0]; half → 0011 or 1100; word → 1111
  - data is the low byte/half of writedata_q replicated across lanes
  - the write happens at posedge when memwrite_q & ~mis & ~stall & ~rst
- Outputs:
  - regwriteo = regwrite_q & ~stall & ~mis
  - memtorego = memtoreg_q
  - writerego = writereg_q
  - aluresulto = aluresult_q
- Exception:
  - on posedge with mis & ~stall & ~exc: exc←1, badaddr←aluresult_q
  - exc and badaddr hold until rst; later misaligned accesses do not overwrite badaddr
- Memory contents are not affected by rst and power up undefined. The bench preloads through hierarchical access.

## Timing
- Reset values: regwriteo=0, memtorego=0, writerego=0, aluresulto=0, readdata=0, exc=0, badaddr=0.
- Latency: EX inputs are sampled at posedge N and appear on the outputs after N. MEM/WB captures them at posedge N+1.
- A store in MEM during cycle N updates the array at posedge N+1. A load in the following cycle to the same word reads the new data with no hazard.
- A load is combinational within its MEM cycle. Read-before-write in the same cycle is impossible because only one instruction occupies MEM.
- Stall:
  - the MEM instruction is frozen, with no memory write and regwriteo=0, so MEM/WB receives a bubble each stalled cycle
  - the instruction completes in the first cycle with stall=0
  - stores and exceptions commit exactly once
- Simultaneous flush and stall: flush wins and the register clears.
- rst mid-store: the write is suppressed in the reset cycle.

## Test plan
- Reset: assert rst for 2 cycles with random inputs → all outputs 0; exc=0.
- Word store/load: sw 0xDEADBEEF to addr 0x10, next cycle lw 0x10 → readdata=0xDEADBEEF, regwriteo=1, memtorego=1, writerego as driven.
- Byte/half extension: word at 0x20 = 0x80FF7F01:
  - lb 0x23 → 0xFFFFFF80
  - lbu 0x23 → 0x00000080
  - lh 0x20 → 0x00007F01
  - lh 0x22 → 0xFFFF80FF
  - sb 0xAA to 0x21 → word becomes 0x80FFAA01
- Misaligned: lw 0x06 → readdata=0, regwriteo=0, exc=1, badaddr=0x06; a following sh 0x09 leaves memory unchanged and badaddr stays 0x06.
- Stall: sw to 0x40 held with stall=1 for 3 cycles → no array change and regwriteo=0 during the stall; the write lands once after release; an ALU instruction under stall reaches regwriteo=1 only after release.
- Flush/wrap: flush during sw → no write, all control outputs 0 next cycle; sw to address 4·2^DEPTH_LOG2 + 4 aliases word 1.
